matrix_input_collector: RTL and testbench
=========================================

Name: matrix_input_collector

Overview:
- Upstream stage of the matrix operator units.
- Accepts a byte stream over a valid/ready handshake: one dimension beat, then m*n elements in row-major order.
- Assembles them into the packed 5x5x8 frame: m_out, n_out, matrix_out, plus a valid flag. This frame drives the transpose, add and other operator units directly.
- Holds the frame until the downstream unit consumes it.

Parameters:
- MAX_DIM, 5, maximum rows/cols; also the row stride of the packed frame.
- ELEM_W, 8, element width in bits.
- TIMEOUT_CYCLES, 1000, idle cycles tolerated between beats (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; name unchanged from the codebase's clock/reset naming.
- clear  in  1  synchronous abort; returns to IDLE and discards the partial matrix.
- in_valid  in  1  in_data is valid.
- in_data  in  8  dimension beat ({1'b0, m[2:0], 1'b0, n[2:0]}) or element beat.
- in_ready  out  1  collector accepts a beat this cycle.
- m_out  out  3  row count of the assembled matrix.
- n_out  out  3  column count of the assembled matrix.
- matrix_out  out  200  element (r,c) at bits [(r*MAX_DIM+c)*ELEM_W +: ELEM_W].
- out_valid  out  1  frame is complete and stable.
- out_ready  in  1  downstream consumes the frame.
- err  out  1  one-cycle pulse on a rejected dimension beat or a timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - in_ready=0 while reset is asserted; 1 from the first clock after release.
  - m_out=0, n_out=0, matrix_out=0, out_valid=0, err=0.
  - row/col counters 0.
- A beat transfers on a rising edge with in_valid & in_ready.
- States:
  - IDLE (in_ready=1):
    - On a dimension beat, latch m=in_data[6:4] and n=in_data[2:0].
    - If 1<=m<=MAX_DIM and 1<=n<=MAX_DIM: clear matrix_out to 0, row=col=0, go to LOAD.
    - Otherwise: err=1 for one cycle, stay in IDLE.
  - LOAD (in_ready=1):
    - Each beat writes in_data to slot (row,col).
    - col increments; when col==n-1, col wraps to 0 and row increments.
    - The beat that writes (m-1,n-1) moves to DONE.
    - Slots outside m x n remain 0.
  - DONE (in_ready=0, out_valid=1):
    - m_out, n_out and matrix_out are held stable.
    - When out_ready=1: out_valid falls the next cycle, go to IDLE.
- Latency: out_valid rises on the clock edge that accepts the last element, so it is visible the cycle after the transfer.
- m_out/n_out update on acceptance of a valid dimension beat. They are meaningful only while out_valid=1.
- Simultaneous events:
  - clear has priority over any beat or out_ready in the same cycle.
  - clear in DONE drops out_valid; no frame is delivered.
  - A beat arriving in DONE is not accepted (in_ready=0), so there is no overwrite hazard.
- A 1x1 matrix goes to DONE after exactly one element beat.
- Reset asserted mid-LOAD or in DONE: immediate return to the reset values; the partial frame is lost.
- err never asserts in the same cycle as out_valid rising.

Optional Feature:
- Macro: MATRIX_COLLECT_TIMEOUT_EN.
- Defined: an idle counter runs in LOAD and resets on every accepted beat. When it reaches TIMEOUT_CYCLES: err pulses for one cycle, matrix_out is cleared, and state returns to IDLE.
- Undefined: LOAD waits indefinitely; counter logic is absent.

Decomposition:
- Shared package matrix_pkg holds:
  - MAX_DIM=5, ELEM_W=8, MAT_W=MAX_DIM*MAX_DIM*ELEM_W (200).
  - Dimension width 3.
  - State enum {IDLE, LOAD, DONE}.
  - Slot-index function (r*MAX_DIM+c)*ELEM_W.
- One natural sub-module: matrix_rc_counter. It is the row/col counter with n-wrap and a last-element flag, and is reusable by downstream serialisers.

Test Plan:
1. Dimension beat 0x13 (1x3), elements 1,2,3 -> out_valid high the cycle after the third accept; m_out=1, n_out=3; slots (0,0)=1, (0,1)=2, (0,2)=3; all other bits 0.
2. Dimension beat 0x55 (5x5), elements 1..25 with in_valid toggling every other cycle -> slot (4,4)=25 at bits [199:192]; in_ready=0 in DONE until out_ready pulses, then IDLE.
3. Dimension beats 0x06 (m=0) and 0x36 (n=6) -> err pulses one cycle each, no state change, out_valid stays 0; a following beat 0x22 is accepted normally.
4. Dimension beat 0x23, three elements, then clear=1 together with in_valid -> beat not written, state IDLE, out_valid never rises.
5. reset driven low mid-LOAD of a 3x3 (after 4 elements) -> all outputs 0 immediately, without waiting for a clock edge; a fresh 2x2 load of 9,8,7,6 then completes correctly.
6. With MATRIX_COLLECT_TIMEOUT_EN and TIMEOUT_CYCLES=8: dimension beat 0x22, one element, then 8 idle cycles -> err pulses, state IDLE, matrix_out=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, state type and slot indexing for the matrix operator units
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ELEM_W  = 8;
    localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int DIM_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // LSB of element (r,c) in a packed frame with the given row stride and element width.
    function automatic int unsigned slot_lsb(input logic [DIM_W-1:0] r,
                                             input logic [DIM_W-1:0] c,
                                             input int unsigned      stride,
                                             input int unsigned      width);
        return ({29'd0, r} * stride + {29'd0, c}) * width;
    endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// rtl/matrix_rc_counter.sv - row/col walker over an m x n matrix with column wrap and last-element flag
module matrix_rc_counter (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       adv,
    input  logic [matrix_pkg::DIM_W-1:0] m,
    input  logic [matrix_pkg::DIM_W-1:0] n,
    output logic [matrix_pkg::DIM_W-1:0] row,
    output logic [matrix_pkg::DIM_W-1:0] col,
    output logic                       last
);
    import matrix_pkg::*;

    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (start) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == n - 3'd1) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == m - 3'd1) && (col_q == n - 3'd1);

endmodule

// File: rtl/matrix_input_collector.sv
// rtl/matrix_input_collector.sv - collects a dimension beat plus m*n bytes into a packed 5x5 frame; MATRIX_COLLECT_TIMEOUT_EN adds an idle timeout
module matrix_input_collector #(
    parameter int MAX_DIM        = matrix_pkg::MAX_DIM,
    parameter int ELEM_W         = matrix_pkg::ELEM_W,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic [ELEM_W-1:0]                 in_data,
    output logic                              in_ready,
    output logic [2:0]                        m_out,
    output logic [2:0]                        n_out,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              err
);
    import matrix_pkg::*;

    localparam int               MW   = MAX_DIM * MAX_DIM * ELEM_W;
    localparam logic [DIM_W-1:0] MAXD = DIM_W'(MAX_DIM);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] m_q, m_d, n_q, n_d;
    logic [MW-1:0]    matrix_q, matrix_d;
    logic             err_q, err_d;
    logic             started_q;

    logic             accept, cnt_start, cnt_adv, cnt_last;
    logic [DIM_W-1:0] row, col, dim_m, dim_n;
    logic             dim_ok;

    assign accept = in_valid && in_ready;
    assign dim_m  = in_data[6:4];
    assign dim_n  = in_data[2:0];
    assign dim_ok = (dim_m != '0) && (dim_m <= MAXD) && (dim_n != '0) && (dim_n <= MAXD);

`ifdef MATRIX_COLLECT_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        timeout;
    assign timeout = (state_q == LOAD) && !accept && (idle_q == 32'(TIMEOUT_CYCLES - 1));
`endif

    matrix_rc_counter u_rc (
        .clk   (clk),
        .reset (reset),
        .start (cnt_start),
        .adv   (cnt_adv),
        .m     (m_q),
        .n     (n_q),
        .row   (row),
        .col   (col),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            n_q       <= '0;
            matrix_q  <= '0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
`ifdef MATRIX_COLLECT_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            matrix_q  <= matrix_d;
            err_q     <= err_d;
            started_q <= 1'b1;
`ifdef MATRIX_COLLECT_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        matrix_d  = matrix_q;
        err_d     = 1'b0;
        cnt_start = 1'b0;
        cnt_adv   = 1'b0;
`ifdef MATRIX_COLLECT_TIMEOUT_EN
        idle_d    = (state_q == LOAD && !accept) ? idle_q + 32'd1 : '0;
`endif
        // clear outranks every beat and out_ready in the same cycle
        if (clear) begin
            state_d   = IDLE;
            matrix_d  = '0;
            cnt_start = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (dim_ok) begin
                            m_d       = dim_m;
                            n_d       = dim_n;
                            matrix_d  = '0;
                            cnt_start = 1'b1;
                            state_d   = LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        matrix_d[slot_lsb(row, col, MAX_DIM, ELEM_W) +: ELEM_W] = in_data;
                        cnt_adv = 1'b1;
                        if (cnt_last) state_d = DONE;
                    end
`ifdef MATRIX_COLLECT_TIMEOUT_EN
                    else if (timeout) begin
                        err_d    = 1'b1;
                        matrix_d = '0;
                        state_d  = IDLE;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready   = started_q && (state_q != DONE);
    assign out_valid  = (state_q == DONE);
    assign m_out      = m_q;
    assign n_out      = n_q;
    assign matrix_out = matrix_q;
    assign err        = err_q;

endmodule

// File: tb/tb_matrix_input_collector.sv
// tb/tb_matrix_input_collector.sv - directed self-checking bench for matrix_input_collector
module tb_matrix_input_collector;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready;
    logic [2:0]   m_out, n_out;
    logic [199:0] matrix_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         err;

    int tests = 0;
    int fails = 0;
    logic [199:0] exp_mat;

    always #5 clk = ~clk;

    matrix_input_collector #(.MAX_DIM(5), .ELEM_W(8), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .m_out      (m_out),
        .n_out      (n_out),
        .matrix_out (matrix_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_out_valid", {199'd0, out_valid}, 200'd0);
        chk("consume_in_ready", {199'd0, in_ready}, 200'd1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {199'd0, in_ready}, 200'd0);
        chk("rst_out_valid", {199'd0, out_valid}, 200'd0);
        chk("rst_err", {199'd0, err}, 200'd0);
        chk("rst_m", {197'd0, m_out}, 200'd0);
        chk("rst_n", {197'd0, n_out}, 200'd0);
        chk("rst_matrix", matrix_out, 200'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", {199'd0, in_ready}, 200'd1);

        // 1x3
        send(8'h13);
        send(8'h01);
        send(8'h02);
        chk("t1_not_done", {199'd0, out_valid}, 200'd0);
        send(8'h03);
        chk("t1_out_valid", {199'd0, out_valid}, 200'd1);
        chk("t1_m", {197'd0, m_out}, 200'd1);
        chk("t1_n", {197'd0, n_out}, 200'd3);
        chk("t1_matrix", matrix_out, 200'h030201);
        chk("t1_in_ready_done", {199'd0, in_ready}, 200'd0);
        consume();

        // 5x5 with in_valid toggling
        send(8'h55);
        exp_mat = '0;
        for (int k = 1; k <= 25; k++) begin
            send(8'(k));
            exp_mat[(k-1)*8 +: 8] = 8'(k);
            if (k < 25) tick();
        end
        chk("t2_out_valid", {199'd0, out_valid}, 200'd1);
        chk("t2_slot44", {192'd0, matrix_out[199:192]}, 200'd25);
        chk("t2_matrix", matrix_out, exp_mat);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        tick();
        chk("t2_in_ready_done", {199'd0, in_ready}, 200'd0);
        chk("t2_held_valid", {199'd0, out_valid}, 200'd1);
        chk("t2_no_overwrite", matrix_out, exp_mat);
        in_valid = 1'b0;
        consume();

        // bad dimension beats
        send(8'h06);
        chk("t3_err_m0", {199'd0, err}, 200'd1);
        chk("t3_ov_m0", {199'd0, out_valid}, 200'd0);
        tick();
        chk("t3_err_pulse", {199'd0, err}, 200'd0);
        send(8'h36);
        chk("t3_err_n6", {199'd0, err}, 200'd1);
        send(8'h22);
        chk("t3_err_ok", {199'd0, err}, 200'd0);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        exp_mat = '0;
        exp_mat[7:0]   = 8'h11;
        exp_mat[15:8]  = 8'h22;
        exp_mat[47:40] = 8'h33;
        exp_mat[55:48] = 8'h44;
        chk("t3_out_valid", {199'd0, out_valid}, 200'd1);
        chk("t3_matrix", matrix_out, exp_mat);
        chk("t3_m", {197'd0, m_out}, 200'd2);
        consume();

        // clear mid-load
        send(8'h23);
        send(8'h05);
        send(8'h06);
        send(8'h07);
        clear = 1'b1;
        send(8'h08);
        clear = 1'b0;
        chk("t4_out_valid", {199'd0, out_valid}, 200'd0);
        chk("t4_matrix", matrix_out, 200'd0);
        tick();
        tick();
        chk("t4_still_idle", {199'd0, out_valid}, 200'd0);
        send(8'h11);
        send(8'h5A);
        chk("t4_fresh_1x1", {199'd0, out_valid}, 200'd1);
        chk("t4_fresh_matrix", matrix_out, 200'h5A);
        consume();

        // async reset mid-load of 3x3
        send(8'h33);
        for (int k = 1; k <= 4; k++) send(8'(k));
        reset = 1'b0;
        #1;
        chk("t5_m", {197'd0, m_out}, 200'd0);
        chk("t5_in_ready", {199'd0, in_ready}, 200'd0);
        chk("t5_matrix", matrix_out, 200'd0);
        tick();
        reset = 1'b1;
        tick();
        send(8'h22);
        send(8'h09);
        send(8'h08);
        send(8'h07);
        send(8'h06);
        exp_mat = '0;
        exp_mat[7:0]   = 8'h09;
        exp_mat[15:8]  = 8'h08;
        exp_mat[47:40] = 8'h07;
        exp_mat[55:48] = 8'h06;
        chk("t5_out_valid", {199'd0, out_valid}, 200'd1);
        chk("t5_matrix", matrix_out, exp_mat);
        consume();

        send(8'h22);
        send(8'h77);
`ifdef MATRIX_COLLECT_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t6_no_err_early", {199'd0, err}, 200'd0);
        end
        tick();
        chk("t6_err", {199'd0, err}, 200'd1);
        chk("t6_matrix", matrix_out, 200'd0);
        chk("t6_in_ready", {199'd0, in_ready}, 200'd1);
        tick();
        chk("t6_err_pulse", {199'd0, err}, 200'd0);
        chk("t6_out_valid", {199'd0, out_valid}, 200'd0);
`else
        for (int k = 1; k <= 20; k++) tick();
        chk("t6_no_timeout_err", {199'd0, err}, 200'd0);
        chk("t6_waiting", {199'd0, out_valid}, 200'd0);
        send(8'h66);
        send(8'h55);
        send(8'h44);
        exp_mat = '0;
        exp_mat[7:0]   = 8'h77;
        exp_mat[15:8]  = 8'h66;
        exp_mat[47:40] = 8'h55;
        exp_mat[55:48] = 8'h44;
        chk("t6_out_valid", {199'd0, out_valid}, 200'd1);
        chk("t6_matrix", matrix_out, exp_mat);
        consume();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
